adsr_envelope: RTL and testbench

Amplitude envelope shaper placed directly downstream of the NCO. It takes the NCO's two's-complement sample stream and scales it by an attack/decay/sustain/release envelope driven by a `gate` input. The output is a note-shaped signal ready for the output DAC/PWM stage. The envelope advances on a programmable prescaled tick, so slow envelopes are possible at the NCO clock rate.

---
 rtl/adsr_envelope.sv | 165 ++++++++++++++++
 tb/tb_adsr_envelope.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope: scales a signed NCO sample stream by an attack/decay/
// sustain/release envelope driven by a gate input. The envelope advances
// on a prescaled tick; gate transitions are acted on every clock.
// state_dbg exposes the FSM encoding:
//   0 = IDLE, 1 = ATTACK, 2 = DECAY, 3 = SUSTAIN, 4 = RELEASE.
module adsr_envelope #(
   parameter int OUT_SIZE = 8,
   parameter int ENV_SIZE = 12,
   parameter int PRESCALE = 1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       gate,
   input  logic [ENV_SIZE-1:0]        attack_rate,
   input  logic [ENV_SIZE-1:0]        decay_rate,
   input  logic [ENV_SIZE-1:0]        sustain_level,
   input  logic [ENV_SIZE-1:0]        release_rate,
   input  logic signed [OUT_SIZE-1:0] signal_in,
   output logic signed [OUT_SIZE-1:0] signal_out,
   output logic [ENV_SIZE-1:0]        envelope,
   output logic                       active,
   output logic [2:0]                 state_dbg
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [ENV_SIZE-1:0] ENV_MAX = {ENV_SIZE{1'b1}};
   localparam logic [ENV_SIZE:0] ENV_MAX_W = {1'b0, ENV_MAX};
   localparam int PW = OUT_SIZE + ENV_SIZE + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   state_t                     state_q;
   logic [ENV_SIZE-1:0]        env_q;
   logic                       active_q;
   logic signed [OUT_SIZE-1:0] out_q;
   logic [CW-1:0]              cnt_q;
   logic [CW-1:0]              cnt_d;
   logic                       tick;

   // Attack sum and decay floor are formed one bit wider so they cannot wrap.
   logic [ENV_SIZE:0] env_w;
   logic [ENV_SIZE:0] atk_sum;
   logic [ENV_SIZE:0] dec_floor;

   // Sample scaling: signed product of the sample and the zero-extended envelope.
   logic signed [PW-1:0] in_ext;
   logic signed [PW-1:0] env_ext;
   logic signed [PW-1:0] prod;
   logic                 unused_prod;

   assign tick  = (cnt_q == CNT_LAST);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);

   assign env_w     = {1'b0, env_q};
   assign atk_sum   = env_w + {1'b0, attack_rate};
   assign dec_floor = {1'b0, sustain_level} + {1'b0, decay_rate};

   assign in_ext  = {{(ENV_SIZE + 1){signal_in[OUT_SIZE-1]}}, signal_in};
   assign env_ext = {{(OUT_SIZE + 1){1'b0}}, env_q};
   assign prod    = in_ext * env_ext;
   // Taking bits above ENV_SIZE is the arithmetic shift; the top bit is
   // always a copy of the sign because |in*env| < 2^(OUT_SIZE+ENV_SIZE-1).
   assign unused_prod = ^{prod[PW-1], prod[ENV_SIZE-1:0]};

   assign signal_out = out_q;
   assign envelope   = env_q;
   assign active     = active_q;
   assign state_dbg  = state_q;

   // Free-running prescale counter; gate never resets it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Envelope FSM: gate transitions win and hold the envelope; otherwise a tick steps it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         env_q    <= '0;
         active_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               env_q <= '0;
               if (gate) begin
                  state_q  <= S_ATTACK;
                  active_q <= 1'b1;
               end
            end
            S_ATTACK: begin
               if (!gate) begin
                  state_q <= S_RELEASE;
               end else if (tick) begin
                  if (atk_sum >= ENV_MAX_W) begin
                     env_q   <= ENV_MAX;
                     state_q <= S_DECAY;
                  end else begin
                     env_q <= atk_sum[ENV_SIZE-1:0];
                  end
               end
            end
            S_DECAY: begin
               if (!gate) begin
                  state_q <= S_RELEASE;
               end else if (tick) begin
                  if (env_w <= dec_floor) begin
                     env_q   <= sustain_level;
                     state_q <= S_SUSTAIN;
                  end else begin
                     env_q <= env_q - decay_rate;
                  end
               end
            end
            S_SUSTAIN: begin
               // Level tracks sustain_level live, independent of the tick.
               if (!gate) begin
                  state_q <= S_RELEASE;
               end else begin
                  env_q <= sustain_level;
               end
            end
            S_RELEASE: begin
               // Retrigger continues the attack from the current level.
               if (gate) begin
                  state_q <= S_ATTACK;
               end else if (tick) begin
                  if (env_q <= release_rate) begin
                     env_q    <= '0;
                     state_q  <= S_IDLE;
                     active_q <= 1'b0;
                  end else begin
                     env_q <= env_q - release_rate;
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               env_q    <= '0;
               active_q <= 1'b0;
            end
         endcase
      end
   end

   // Registered scaled output: one clock after the sample and envelope it uses.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_q <= '0;
      end else begin
         out_q <= prod[ENV_SIZE +: OUT_SIZE];
      end
   end

endmodule

// File: tb/tb_adsr_envelope.sv
// Testbench for adsr_envelope: directed vectors, expected values pushed to a
// cycle-tagged queue by the driver and popped by a monitor after each edge.
module tb_adsr_envelope;

   localparam int ST_IDLE    = 0;
   localparam int ST_ATTACK  = 1;
   localparam int ST_DECAY   = 2;
   localparam int ST_SUSTAIN = 3;
   localparam int ST_RELEASE = 4;

   // Clock / reset
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // DUT 1 (PRESCALE = 1)
   logic              gate = 1'b0;
   logic [11:0]       attack_rate = '0;
   logic [11:0]       decay_rate = '0;
   logic [11:0]       sustain_level = '0;
   logic [11:0]       release_rate = '0;
   logic signed [7:0] signal_in = '0;
   logic signed [7:0] signal_out;
   logic [11:0]       envelope;
   logic              active;
   logic [2:0]        state_dbg;

   // DUT 2 (PRESCALE = 4)
   logic              gate2 = 1'b0;
   logic [11:0]       attack2 = 12'd100;
   logic [11:0]       decay2 = 12'd0;
   logic [11:0]       sustain2 = 12'd0;
   logic [11:0]       release2 = 12'd50;
   logic signed [7:0] signal_in2 = '0;
   logic signed [7:0] signal_out2;
   logic [11:0]       envelope2;
   logic              active2;
   logic [2:0]        state_dbg2;

   adsr_envelope #(.OUT_SIZE(8), .ENV_SIZE(12), .PRESCALE(1)) dut (
      .clock(clock), .reset_n(reset_n), .gate(gate),
      .attack_rate(attack_rate), .decay_rate(decay_rate),
      .sustain_level(sustain_level), .release_rate(release_rate),
      .signal_in(signal_in), .signal_out(signal_out),
      .envelope(envelope), .active(active), .state_dbg(state_dbg)
   );

   adsr_envelope #(.OUT_SIZE(8), .ENV_SIZE(12), .PRESCALE(4)) dut_ps (
      .clock(clock), .reset_n(reset_n), .gate(gate2),
      .attack_rate(attack2), .decay_rate(decay2),
      .sustain_level(sustain2), .release_rate(release2),
      .signal_in(signal_in2), .signal_out(signal_out2),
      .envelope(envelope2), .active(active2), .state_dbg(state_dbg2)
   );

   // Scoreboard
   typedef struct {
      int cyc;
      int sel;
      int exp;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_cnt  = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic string sel_name(input int sel);
      case (sel)
         0:       return "envelope";
         1:       return "signal_out";
         2:       return "active";
         3:       return "state";
         4:       return "ps_envelope";
         5:       return "ps_active";
         default: return "ps_state";
      endcase
   endfunction

   function automatic int actual(input int sel);
      case (sel)
         0:       return int'(envelope);
         1:       return int'(signal_out);
         2:       return int'(active);
         3:       return int'(state_dbg);
         4:       return int'(envelope2);
         5:       return int'(active2);
         default: return int'(state_dbg2);
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_cnt, act, exp);
      end
   endtask

   // Monitor: after each rising edge, compare every expectation due this cycle.
   always @(posedge clock) begin
      exp_t e;
      #1;
      cyc_cnt++;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
         e = exp_q.pop_front();
         check(sel_name(e.sel), actual(e.sel), e.exp);
      end
   end

   // Driver tasks: called just after a falling edge, expectations target the next edge.
   task automatic push(input int sel, input int v);
      exp_t e;
      e.cyc = cyc_cnt + 1;
      e.sel = sel;
      e.exp = v;
      exp_q.push_back(e);
   endtask

   task automatic exp_out(input int v);
      push(1, v);
   endtask

   task automatic step1(input int e, input int a, input int s);
      push(0, e);
      push(2, a);
      push(3, s);
      @(negedge clock);
   endtask

   task automatic step2(input int e, input int a, input int s);
      push(4, e);
      push(5, a);
      push(6, s);
      @(negedge clock);
   endtask

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Stimulus
   initial begin
      repeat (3) @(negedge clock);
      check("reset_envelope", int'(envelope), 0);
      check("reset_signal_out", int'(signal_out), 0);
      check("reset_active", int'(active), 0);
      check("reset_state", int'(state_dbg), ST_IDLE);

      // Prescale = 4: steps only on edges 4, 8, 12, 16; gate acts immediately.
      reset_n = 1'b1;
      gate2   = 1'b1;
      step2(0, 1, ST_ATTACK);
      step2(0, 1, ST_ATTACK);
      step2(0, 1, ST_ATTACK);
      step2(100, 1, ST_ATTACK);
      step2(100, 1, ST_ATTACK);
      step2(100, 1, ST_ATTACK);
      step2(100, 1, ST_ATTACK);
      step2(200, 1, ST_ATTACK);
      step2(200, 1, ST_ATTACK);
      gate2 = 1'b0;
      step2(200, 1, ST_RELEASE);
      step2(200, 1, ST_RELEASE);
      step2(150, 1, ST_RELEASE);
      step2(150, 1, ST_RELEASE);
      step2(150, 1, ST_RELEASE);
      step2(150, 1, ST_RELEASE);
      step2(100, 1, ST_RELEASE);

      // Full ADSR cycle
      attack_rate   = 12'd1024;
      decay_rate    = 12'd512;
      sustain_level = 12'd2048;
      release_rate  = 12'd1000;
      gate = 1'b1;
      step1(0, 1, ST_ATTACK);
      step1(1024, 1, ST_ATTACK);
      step1(2048, 1, ST_ATTACK);
      step1(3072, 1, ST_ATTACK);
      step1(4095, 1, ST_DECAY);
      step1(3583, 1, ST_DECAY);
      step1(3071, 1, ST_DECAY);
      step1(2559, 1, ST_DECAY);
      step1(2048, 1, ST_SUSTAIN);
      step1(2048, 1, ST_SUSTAIN);
      gate = 1'b0;
      step1(2048, 1, ST_RELEASE);
      step1(1048, 1, ST_RELEASE);
      step1(48, 1, ST_RELEASE);
      step1(0, 0, ST_IDLE);
      step1(0, 0, ST_IDLE);

      // Scaling, with sustain at ENV_MAX so DECAY ends on its first tick
      attack_rate   = 12'd4095;
      sustain_level = 12'd4095;
      gate = 1'b1;
      step1(0, 1, ST_ATTACK);
      step1(4095, 1, ST_DECAY);
      step1(4095, 1, ST_SUSTAIN);
      signal_in = 8'sd100;
      exp_out(99);
      step1(4095, 1, ST_SUSTAIN);
      signal_in = -8'sd128;
      exp_out(-128);
      step1(4095, 1, ST_SUSTAIN);
      sustain_level = 12'd2048;
      signal_in = 8'sd0;
      exp_out(0);
      step1(2048, 1, ST_SUSTAIN);
      signal_in = 8'sd100;
      exp_out(50);
      step1(2048, 1, ST_SUSTAIN);
      signal_in = -8'sd1;
      exp_out(-1);
      step1(2048, 1, ST_SUSTAIN);
      gate = 1'b0;
      release_rate = 12'd4095;
      signal_in = 8'sd0;
      step1(2048, 1, ST_RELEASE);
      step1(0, 0, ST_IDLE);
      signal_in = 8'sd127;
      exp_out(0);
      step1(0, 0, ST_IDLE);

      // Gate drop in ATTACK, then retrigger in RELEASE
      attack_rate   = 12'd1024;
      decay_rate    = 12'd512;
      sustain_level = 12'd2048;
      release_rate  = 12'd1000;
      signal_in = 8'sd0;
      gate = 1'b1;
      step1(0, 1, ST_ATTACK);
      step1(1024, 1, ST_ATTACK);
      step1(2048, 1, ST_ATTACK);
      gate = 1'b0;
      step1(2048, 1, ST_RELEASE);
      step1(1048, 1, ST_RELEASE);
      gate = 1'b1;
      step1(1048, 1, ST_ATTACK);
      step1(2072, 1, ST_ATTACK);
      step1(3096, 1, ST_ATTACK);
      step1(4095, 1, ST_DECAY);
      step1(3583, 1, ST_DECAY);
      step1(3071, 1, ST_DECAY);
      step1(2559, 1, ST_DECAY);
      step1(2048, 1, ST_SUSTAIN);
      signal_in = 8'sd100;
      exp_out(50);
      step1(2048, 1, ST_SUSTAIN);

      // Asynchronous reset between edges during SUSTAIN
      #2;
      reset_n = 1'b0;
      #1;
      check("async_reset_envelope", int'(envelope), 0);
      check("async_reset_signal_out", int'(signal_out), 0);
      check("async_reset_active", int'(active), 0);
      check("async_reset_state", int'(state_dbg), ST_IDLE);
      @(negedge clock);
      reset_n = 1'b1;
      step1(0, 1, ST_ATTACK);
      step1(1024, 1, ST_ATTACK);

      repeat (2) @(negedge clock);
      if (exp_q.size() != 0) check("leftover_expectations", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
